// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column, debounces the first
// row hit found and reports it as a single key_valid pulse plus key_held.
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    // state    | meaning
    // SCAN     | column walks one step per tick, looking for any low row
    // DEBOUNCE | column frozen, counting consecutive low samples on row_idx
    // HELD     | key accepted, counting consecutive high samples for release
    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int MW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] DWELL_MAX = CW'(SCAN_DIV - 1);
    localparam logic [MW-1:0] MATCH_MAX = MW'(DEBOUNCE_TICKS);

    state_t        state, state_n;
    logic [3:0]    r_meta, rs;
    logic [CW-1:0] dwell;
    logic          tick;
    logic [1:0]    col_idx, row_idx, low_idx;
    logic [MW-1:0] match_cnt, rel_cnt;
    logic          key_low;
    logic          latch, advance, accept, release_done;
    logic          match_inc, match_clr, rel_inc, rel_clr;

    assign tick    = (dwell == DWELL_MAX);
    assign key_low = ~rs[row_idx];

    always_comb begin
        low_idx = 2'd3;
        if (!rs[0])      low_idx = 2'd0;
        else if (!rs[1]) low_idx = 2'd1;
        else if (!rs[2]) low_idx = 2'd2;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= SCAN;
        else     state <= state_n;
    end

    always_comb begin
        state_n      = state;
        latch        = 1'b0;
        advance      = 1'b0;
        accept       = 1'b0;
        release_done = 1'b0;
        match_inc    = 1'b0;
        match_clr    = 1'b0;
        rel_inc      = 1'b0;
        rel_clr      = 1'b0;
        case (state)
            SCAN: begin
                if (tick && rs != 4'b1111) begin
                    latch   = 1'b1;
                    state_n = DEBOUNCE;
                end else if (tick) begin
                    advance = 1'b1;
                end
            end
            DEBOUNCE: begin
                // acceptance is checked before the next tick so a count of 1 works
                if (match_cnt == MATCH_MAX) begin
                    accept  = 1'b1;
                    state_n = HELD;
                end else if (tick && key_low) begin
                    match_inc = 1'b1;
                end else if (tick) begin
                    match_clr = 1'b1;
                    advance   = 1'b1;
                    state_n   = SCAN;
                end
            end
            HELD: begin
                if (rel_cnt == MATCH_MAX) begin
                    release_done = 1'b1;
                    match_clr    = 1'b1;
                    rel_clr      = 1'b1;
                    advance      = 1'b1;
                    state_n      = SCAN;
                end else if (tick && !key_low) begin
                    rel_inc = 1'b1;
                end else if (tick) begin
                    rel_clr = 1'b1;
                end
            end
            default: state_n = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta    <= 4'b1111;
            rs        <= 4'b1111;
            dwell     <= '0;
            col       <= 4'b1110;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            match_cnt <= '0;
            rel_cnt   <= '0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            r_meta    <= row;
            rs        <= r_meta;
            dwell     <= tick ? '0 : dwell + CW'(1);
            key_valid <= accept;
            if (advance) begin
                col     <= {col[2:0], col[3]};
                col_idx <= col_idx + 2'd1;
            end
            if (latch) begin
                row_idx   <= low_idx;
                match_cnt <= MW'(1);
            end else if (match_inc) begin
                match_cnt <= match_cnt + MW'(1);
            end else if (match_clr) begin
                match_cnt <= '0;
            end
            if (rel_inc)      rel_cnt <= rel_cnt + MW'(1);
            else if (rel_clr) rel_cnt <= '0;
            if (accept) begin
                key_code <= {row_idx, col_idx};
                key_held <= 1'b1;
            end
            if (release_done) key_held <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a switch-matrix model drives the rows, a scoreboard
// queue holds expected key presses and a monitor checks every key_valid pulse.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DT       = 3;
    localparam int LAT_MAX  = 2 + (4 + DT) * SCAN_DIV + 1;

    typedef struct {
        logic [3:0] code;
        int         t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row, col, key_code;
    logic        key_valid, key_held;
    logic [15:0] pressed = '0;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   phase       = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic prev_kv = 1'b0;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_TICKS(DT)) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // a closed switch pulls its row low only while its column is driven low
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    // free-running dwell position, used only to align stimulus to ticks
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        phase <= rst ? 0 : ((phase == SCAN_DIV - 1) ? 0 : phase + 1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            if (prev_kv) begin
                check("pulse_width", 1, 0);
            end else if (sb.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("key_code", 32'(key_code), 32'(mon_e.code));
                check("held_at_pulse", 32'(key_held), 1);
                check("latency_ok", 32'((cyc - mon_e.t) <= LAT_MAX), 1);
            end
        end
        prev_kv = key_valid;
    end

    task automatic press(input int k);
        exp_t e;
        pressed[k] = 1'b1;
        e.code = 4'(k);
        e.t    = cyc;
        sb.push_back(e);
    endtask

    task automatic to_dwell_start();
        @(negedge clk);
        while (phase != 0) @(negedge clk);
    endtask

    task automatic wait_col(input logic [3:0] c, input string name);
        int n = 0;
        to_dwell_start();
        while (col !== c && n < 8) begin
            to_dwell_start();
            n++;
        end
        check(name, 32'(col), 32'(c));
    endtask

    task automatic wait_held(input logic lvl, input int budget, input string name);
        int n = 0;
        @(negedge clk);
        while (key_held !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(key_held), 32'(lvl));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] prev;
        int n, trans, bad_held;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_col", 32'(col), 32'(4'b1110));
        check("reset_key_code", 32'(key_code), 0);
        check("reset_valid", 32'(key_valid), 0);
        check("reset_held", 32'(key_held), 0);
        rst = 1'b0;

        // idle scan
        prev = col; n = 0; trans = 0; bad_held = 0;
        repeat (64) begin
            @(negedge clk);
            n++;
            if (key_held !== 1'b0) bad_held++;
            if (col !== prev) begin
                check("idle_col_seq", 32'(col), 32'({prev[2:0], prev[3]}));
                check("idle_dwell", n, SCAN_DIV);
                prev = col;
                n = 0;
                trans++;
            end
        end
        check("idle_transitions", trans, 16);
        check("idle_held", bad_held, 0);

        // key 6: row 1, column 2
        press(6);
        wait_held(1'b1, 60, "key6_accept");
        check("key6_col_frozen", 32'(col), 32'(4'b1011));
        repeat (3) to_dwell_start();
        check("key6_col_hold", 32'(col), 32'(4'b1011));
        check("key6_still_held", 32'(key_held), 1);
        pressed[6] = 1'b0;
        wait_held(1'b0, 60, "key6_release");
        check("key6_next_col", 32'(col), 32'(4'b0111));
        check("key6_code_kept", 32'(key_code), 6);

        // press bounce on key 0
        wait_col(4'b1110, "bounce_col0");
        pressed[0] = 1'b1;
        to_dwell_start();
        check("bounce_frozen", 32'(col), 32'(4'b1110));
        pressed[0] = 1'b0;
        to_dwell_start();
        check("bounce_abort", 32'(col), 32'(4'b1101));
        press(0);
        wait_held(1'b1, 60, "bounce_accept");

        // release bounce: high, high, low, then high steadily
        to_dwell_start();
        pressed[0] = 1'b0;
        to_dwell_start();
        to_dwell_start();
        pressed[0] = 1'b1;
        to_dwell_start();
        pressed[0] = 1'b0;
        to_dwell_start();
        to_dwell_start();
        check("rel_bounce_held", 32'(key_held), 1);
        to_dwell_start();
        check("rel_third_tick", 32'(key_held), 1);
        @(negedge clk);
        check("rel_drop", 32'(key_held), 0);
        check("rel_next_col", 32'(col), 32'(4'b1101));
        check("rel_code_kept", 32'(key_code), 0);

        // rows 0 and 1 on column 3, then a third key in the same column
        press(3);
        pressed[7] = 1'b1;
        wait_held(1'b1, 60, "multi_accept");
        check("multi_col", 32'(col), 32'(4'b0111));
        pressed[11] = 1'b1;
        repeat (3) to_dwell_start();
        check("multi_held", 32'(key_held), 1);
        pressed = '0;
        wait_held(1'b0, 60, "multi_release");
        check("multi_wrap", 32'(col), 32'(4'b1110));
        check("multi_code", 32'(key_code), 3);

        // reset while HELD
        press(5);
        wait_held(1'b1, 60, "key5_accept");
        to_dwell_start();
        pressed[5] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_held_col", 32'(col), 32'(4'b1110));
        check("rst_held_held", 32'(key_held), 0);
        check("rst_held_code", 32'(key_code), 0);
        check("rst_held_valid", 32'(key_valid), 0);
        rst = 1'b0;

        // reset while DEBOUNCE: no pulse may follow
        wait_col(4'b1101, "dbn_col1");
        pressed[1] = 1'b1;
        to_dwell_start();
        to_dwell_start();
        check("dbn_frozen", 32'(col), 32'(4'b1101));
        rst = 1'b1;
        pressed[1] = 1'b0;
        @(negedge clk);
        check("dbn_rst_col", 32'(col), 32'(4'b1110));
        check("dbn_rst_held", 32'(key_held), 0);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("dbn_no_hold", 32'(key_held), 0);

        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 100000, sets the clocks per column dwell (1 ms at 100 MHz); legal minimum is 2.
REQ-002 Parameter DEBOUNCE_TICKS, default 20, sets the consecutive matching row samples required to accept a press or a release; legal minimum is 1.
REQ-003 The design SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port clk, input, 1 bit: 100 MHz system clock; all logic on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port row, input, 4 bits: keypad row returns, active low (pulled up), asynchronous to clk.
REQ-007 Port col, output, 4 bits: column drive, active low, one-hot-low, registered.
REQ-008 Port key_code, output, 4 bits: last accepted key, equal to row_idx*4 + col_idx.
REQ-009 Port key_valid, output, 1 bit: one-cycle pulse when a debounced press is accepted.
REQ-010 Port key_held, output, 1 bit: high from acceptance until the debounced release.

Function
REQ-011 The row input SHALL pass through a 2-flop synchronizer; all row decisions SHALL use the synchronized value (rs).
REQ-012 A dwell counter SHALL count 0..SCAN_DIV-1 and wrap; "tick" is the cycle in which it equals SCAN_DIV-1.
REQ-013 The column sequence SHALL be 1110, 1101, 1011, 0111 (col_idx 0..3), wrapping 0111 -> 1110; col advances on a tick only in state SCAN.
REQ-014 The state machine SHALL have three states: SCAN, DEBOUNCE and HELD; the column is frozen in DEBOUNCE and HELD.
REQ-015 In SCAN, on a tick with rs != 4'b1111, the block SHALL latch row_idx as the lowest-index low bit of rs, set the match count to 1, freeze the column and enter DEBOUNCE; if DEBOUNCE_TICKS == 1, it accepts immediately per REQ-017.
REQ-016 In DEBOUNCE, on each tick: if rs[row_idx] is low, the match count increments; if it is high, the match count clears, the column advances, and the state returns to SCAN.
REQ-017 Acceptance occurs when the match count reaches DEBOUNCE_TICKS; in the next cycle key_valid = 1 for exactly one cycle, key_code is updated in that same cycle, key_held = 1, and the state enters HELD.
REQ-018 In HELD, on each tick: if rs[row_idx] is high, the release count increments; if it is low, the release count clears.
REQ-019 When the release count reaches DEBOUNCE_TICKS, the next cycle SHALL drive key_held = 0, clear both counts, advance the column, and enter SCAN.
REQ-020 Presses on other rows or columns during DEBOUNCE or HELD SHALL be ignored; no second key_valid may occur until after release.
REQ-021 key_code SHALL hold its value between acceptances, including through release.
REQ-022 The dwell counter SHALL free-run in every state; ticks never stall.
REQ-023 Press-to-key_valid latency SHALL be at most 2 sync cycles + (4 + DEBOUNCE_TICKS) * SCAN_DIV + 1 clocks.

Reset
REQ-024 While rst = 1 at a clock edge, the next state SHALL be: col = 1110, key_code = 0, key_valid = 0, key_held = 0, state = SCAN, and dwell, match, release and synchronizer registers at 0/1111.
REQ-025 A reset asserted in DEBOUNCE or HELD SHALL abort the operation with no key_valid pulse; scanning restarts at col_idx 0 with the dwell count at 0.

Verification (SCAN_DIV=4, DEBOUNCE_TICKS=3)
REQ-026 Idle, row = 1111 for 64 cycles -> col cycles 1110, 1101, 1011, 0111 every 4 clocks; key_valid never asserts; key_held = 0.
REQ-027 Hold row = 1101 while col = 1011 -> exactly one key_valid pulse with key_code = 6, then key_held = 1 and col stays 1011 until release.
REQ-028 Bounce: row low for 1 tick, high for 1 tick, then low steadily -> no pulse from the first contact; one pulse after 3 consecutive low samples.
REQ-029 Release bounce: in HELD, row high for 2 ticks, low for 1 tick, then high steadily -> key_held drops only after 3 consecutive high samples; scanning resumes at the next column.
REQ-030 Two rows low (row = 1100) on column 3 -> key_code = 3 (row 0 wins); a second key pressed while held gives no extra pulse.
REQ-031 rst pulsed during HELD -> col = 1110, key_held = 0, key_code = 0 on the next cycle; no key_valid pulse.
